// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch front end: FSM state, entry layout, PC step.
// Entry widths here set the queue payload; the top's DATA_WIDTH/ADDR_WIDTH must match them.
package fetch_pkg;

    localparam int INSTR_BYTES  = 4;
    localparam int FETCH_ADDR_W = 32;
    localparam int FETCH_DATA_W = 32;

    typedef enum logic {
        FETCH = 1'b0,
        FLUSH = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic [FETCH_DATA_W-1:0] instruction;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of DEPTH entries, with clear and an always-visible head; push to visible head is one cycle.
// No internal backpressure: the caller's credit accounting keeps pushes off a full queue, and overflowing pushes are ignored.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    input  logic             i_clear,
    output logic [CW-1:0]    o_count,
    output logic [WIDTH-1:0] o_head_dat
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic             w_push_ok;
    logic             w_pop_ok;
    logic [CW-1:0]    w_count_nxt;

    assign w_push_ok = i_push && (r_count != CW'(DEPTH));
    assign w_pop_ok  = i_pop && (r_count != '0);

    always_comb begin
        w_count_nxt = r_count + CW'(w_push_ok) - CW'(w_pop_ok);
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= i_push_dat;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= w_count_nxt;
        end
    end

    assign o_count    = r_count;
    assign o_head_dat = r_mem[r_rd_ptr];

endmodule

// File: rtl/instruction_fetch_queue.sv
// RV32I fetch front end: PC, credit-limited in-order imem requests, response queue to decode, redirect flush.
// Fetch-to-decode latency is memory latency + 1; requests stall when queued + outstanding reaches DEPTH.
module instruction_fetch_queue
    import fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rstn,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instruction,
    output logic [ADDR_WIDTH-1:0] out_pc
);

    localparam int CW    = $clog2(DEPTH + 1);
    localparam int SUM_W = CW + 1;
    localparam int EW    = $bits(fetch_entry_t);

    fetch_state_t          r_state;
    fetch_state_t          w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic [ADDR_WIDTH-1:0] r_rsp_pc;
    logic [CW-1:0]         r_outstanding;
    logic [CW-1:0]         r_drop_cnt;
    logic [CW-1:0]         w_drop_nxt;
    logic [CW-1:0]         w_outstanding_nxt;
    logic [CW-1:0]         w_count;
    logic [SUM_W-1:0]      w_inflight;
    logic                  w_fetch_en;
    logic                  w_credit_ok;
    logic                  w_req_fire;
    logic                  w_push;
    logic                  w_pop;
    fetch_entry_t          w_push_entry;
    fetch_entry_t          w_head_entry;
    logic [EW-1:0]         w_head_dat;

    // Queued entries plus requests still owed by memory bound what may be issued.
    assign w_inflight  = {1'b0, w_count} + {1'b0, r_outstanding};
    assign w_credit_ok = w_inflight < SUM_W'(DEPTH);

    assign imem_req_valid = rstn && w_fetch_en && !redirect_valid && w_credit_ok;
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    assign w_push = imem_rsp_valid && (r_drop_cnt == '0) && !redirect_valid;
    assign w_pop  = out_valid && out_ready && !redirect_valid;

    always_comb begin
        w_drop_nxt = r_drop_cnt;
        if (redirect_valid) begin
            w_drop_nxt = r_outstanding - CW'(imem_rsp_valid);
        end else if (imem_rsp_valid && (r_drop_cnt != '0)) begin
            w_drop_nxt = r_drop_cnt - CW'(1);
        end
    end

    always_comb begin
        w_outstanding_nxt = r_outstanding + CW'(w_req_fire) - CW'(imem_rsp_valid);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Leaving FLUSH coincides with the last stale response, so fetch resumes the next cycle.
    always_comb begin
        w_state_nxt = r_state;
        if (redirect_valid) begin
            w_state_nxt = (w_drop_nxt != '0) ? FLUSH : FETCH;
        end else if ((r_state == FLUSH) && (w_drop_nxt == '0)) begin
            w_state_nxt = FETCH;
        end
    end

    always_comb begin
        w_fetch_en = (r_state == FETCH);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_outstanding <= w_outstanding_nxt;
            r_drop_cnt    <= w_drop_nxt;
            if (redirect_valid) begin
                r_fetch_pc <= redirect_pc;
                r_rsp_pc   <= redirect_pc;
            end else begin
                if (w_req_fire) begin
                    r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(INSTR_BYTES);
                end
                if (w_push) begin
                    r_rsp_pc <= r_rsp_pc + ADDR_WIDTH'(INSTR_BYTES);
                end
            end
        end
    end

    always_comb begin
        w_push_entry             = '0;
        w_push_entry.pc          = r_rsp_pc;
        w_push_entry.instruction = imem_rsp_data;
    end

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk      (clk),
        .i_rstn     (rstn),
        .i_push     (w_push),
        .i_push_dat (w_push_entry),
        .i_pop      (w_pop),
        .i_clear    (redirect_valid),
        .o_count    (w_count),
        .o_head_dat (w_head_dat)
    );

    assign w_head_entry    = fetch_entry_t'(w_head_dat);
    assign out_valid       = (w_count != '0);
    assign out_pc          = w_head_entry.pc;
    assign out_instruction = w_head_entry.instruction;

endmodule

// File: doc/instruction_fetch_queue.md
# instruction_fetch_queue

Instruction fetch front end for the single-issue RV32I core. It holds the PC, issues in-order requests to instruction memory under a valid/ready handshake, and buffers returned words with their PCs in a small FIFO. It presents one instruction at a time to decode; the immediate generator and decoder sit directly downstream. A redirect from execute (branch, jal, jalr) flushes the buffer and discards in-flight responses.

## Interface
- DATA_WIDTH, 32, instruction word width
- ADDR_WIDTH, 32, PC / memory address width
- DEPTH, 4, queue entries; power of two, ≥2
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  single clock, rising edge
- rstn  in  1  asynchronous, active-low reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  ADDR_WIDTH  fetch address
- imem_rsp_valid  in  1  response valid; in order, ≥1 cycle after acceptance, cannot be back-pressured
- imem_rsp_data  in  DATA_WIDTH  fetched instruction
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  ADDR_WIDTH  new fetch address
- out_valid  out  1  head entry valid
- out_ready  in  1  decode consumes head
- out_instruction  out  DATA_WIDTH  head instruction
- out_pc  out  ADDR_WIDTH  head PC

## Operation
- State registers: fetch_pc, rsp_pc, count (0..DEPTH), outstanding (0..DEPTH), drop_cnt (0..DEPTH), state ∈ {FETCH, FLUSH}. Counter width is $clog2(DEPTH+1).
- Reset values: fetch_pc = rsp_pc = RESET_PC, count = outstanding = drop_cnt = 0, state = FETCH. imem_req_valid = 0 and out_valid = 0 while rstn is low.
- imem_req_valid = (state == FETCH) && !redirect_valid && (count + outstanding < DEPTH).
  - It never depends on imem_req_ready.
  - imem_req_addr = fetch_pc.
  - Address is held stable until accepted; withdrawal is allowed only on redirect.
- Request accept (valid && ready): fetch_pc += 4 (wraps modulo 2^ADDR_WIDTH); outstanding += 1.
- Response with drop_cnt == 0: push {rsp_pc, imem_rsp_data}; rsp_pc += 4; outstanding −= 1. The credit check guarantees the FIFO never overflows.
- Response with drop_cnt > 0: discard it; drop_cnt −= 1; outstanding −= 1.
- Pop: out_valid && out_ready && !redirect_valid. Simultaneous push and pop leaves count unchanged.
- out_valid = (count != 0). out_instruction and out_pc come from the head entry. No response-to-output bypass.
- Redirect (highest priority):
  - count ← 0; fetch_pc ← rsp_pc ← redirect_pc.
  - Any push or pop in the same cycle is cancelled.
  - A response arriving that cycle is discarded.
  - drop_cnt ← outstanding − (imem_rsp_valid ? 1 : 0).
  - state ← FLUSH if the new drop_cnt > 0, else FETCH.
- FLUSH: no requests are issued. Return to FETCH on the cycle drop_cnt reaches 0.
- Redirect while in FLUSH restarts the flush with the recomputed drop_cnt and the latest redirect_pc.
- Reset mid-operation clears all state asynchronously. Responses still owed by memory are the memory's responsibility to squash on the same reset.

## Timing
- First request: the first rising edge after rstn deasserts, at address RESET_PC.
- Fetch-to-decode latency: memory latency + 1 cycle (response registered into the FIFO).
- Zero-wait memory with out_ready held high: throughput is 1 instruction per cycle once the pipe fills.
- Redirect with no outstanding requests: new request issued in the cycle after redirect.
- Redirect with N outstanding: the first new request is issued the cycle after the Nth stale response.
- Full condition: count + outstanding == DEPTH stalls requests. It releases in the cycle after a pop.

## Structure
- Package fetch_pkg holds:
  - the state typedef {FETCH, FLUSH}
  - INSTR_BYTES = 4
  - the queue entry struct {pc, instruction}
- Sub-module fetch_fifo: synchronous FIFO of DEPTH entries with push, pop, clear, count, and head outputs; asynchronous active-low reset.
- PC, credit, and drop logic live in the top module.

## Test plan
- Reset release, 1-cycle memory, out_ready = 1:
  - requests at 0x0, 0x4, 0x8 on consecutive cycles
  - out_pc 0x0 appears 2 cycles after the first accept, then one instruction per cycle
- out_ready = 0, DEPTH = 4:
  - exactly 4 requests issued, count = 4, imem_req_valid stays 0
  - one pop re-enables a request the next cycle
- Redirect to 0x100 with 2 outstanding and 3-cycle memory:
  - both stale responses dropped, out_valid low through the flush
  - next request at 0x100, first out_pc = 0x100
- Redirect in the same cycle as a response and a pop:
  - response discarded, count = 0, drop_cnt = outstanding − 1
  - head not consumed twice
- imem_req_ready low for 5 cycles: imem_req_addr is held at 0x8 throughout, and fetch_pc does not advance.
- fetch_pc = 0xFFFF_FFFC: the next request wraps to 0x0000_0000.
